// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline boundary registers: payload layouts,
// per-boundary widths and the stage occupancy state encoding.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   typedef struct packed {
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] badvaddr;
      logic        we;
      logic        bd;
      logic [4:0]  addr;
      logic        eret;
   } cp0_info_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [4:0]  rd;
      logic [1:0]  rf_wsel;
      cp0_info_t   cp0;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_out;
      logic [31:0] rdata2;
      logic [4:0]  rd;
      logic [1:0]  rf_wsel;
      logic [63:0] hilo;
      cp0_info_t   cp0;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_out;
      logic [4:0]  rd;
      logic [1:0]  rf_wsel;
      logic [63:0] hilo;
   } mem_wb_t;

   localparam int IF_ID_W  = $bits(if_id_t);
   localparam int ID_EX_W  = $bits(id_ex_t);
   localparam int EX_MEM_W = $bits(ex_mem_t);
   localparam int MEM_WB_W = $bits(mem_wb_t);

   function automatic logic [1:0] state_occupancy(input stage_state_e s);
      case (s)
         ONE:     return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline boundary register with optional one-entry skid
// buffer and synchronous flush; payload is carried opaquely.
module pipe_stage_reg
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W         = 64,
   parameter bit SKID           = 1'b1,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   stage_state_e      state;
   logic              main_valid;
   logic              skid_valid;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] skid_data;
   logic              in_fire;
   logic              out_fire;

   // With the skid entry, ready depends only on a flop, breaking the ready chain.
   assign in_ready  = SKID ? !skid_valid : (!main_valid || out_ready);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = main_valid && out_ready;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign occupancy = state_occupancy(state);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         if (CLEAR_ON_FLUSH) begin
            main_data <= '0;
            skid_data <= '0;
         end
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_data  <= in_data;
                  main_valid <= 1'b1;
                  state      <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_data <= in_data;
               end else if (in_fire) begin
                  // Without a skid entry ready implies out_ready, so this only fills the skid.
                  if (SKID) begin
                     skid_data  <= in_data;
                     skid_valid <= 1'b1;
                     state      <= FULL;
                  end else begin
                     main_data <= in_data;
                  end
               end else if (out_fire) begin
                  main_valid <= 1'b0;
                  state      <= EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_data  <= skid_data;
                  skid_valid <= 1'b0;
                  state      <= ONE;
               end
            end
            default: begin
               state      <= EMPTY;
               main_valid <= 1'b0;
               skid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Checks a skid and a pass-through instance of pipe_stage_reg against
// queue-based FIFO models, with directed scenarios and random traffic.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;

   logic        in_ready1, out_valid1, in_ready0, out_valid0;
   logic [63:0] out_data1, out_data0;
   logic [1:0]  occ1, occ0;

   logic [63:0] q1[$];
   logic [63:0] q0[$];
   int          compare_count = 0;
   int          mismatch_count = 0;
   bit          checks_on = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(64), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1)) dut_skid (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .occupancy(occ1)
   );

   pipe_stage_reg #(.DATA_W(64), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1)) dut_pass (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .occupancy(occ0)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle, checks both instances against their FIFO models mid-cycle,
   // then advances the models by the transfers that happen on the rising edge.
   task automatic applyStimulus(input logic rst_n, input logic v, input logic [63:0] d,
                                input logic ordy, input logic fl);
      logic        fire_in1, fire_out1, fire_in0, fire_out0;
      logic [63:0] popped;
      resetn = rst_n; in_valid = v; in_data = d; out_ready = ordy; flush = fl;
      @(negedge clk);
      if (checks_on) begin
         checkOutput("skid_valid", 64'(out_valid1), 64'(q1.size() != 0));
         if (q1.size() != 0) checkOutput("skid_data", out_data1, q1[0]);
         checkOutput("skid_in_ready", 64'(in_ready1), 64'(q1.size() < 2));
         checkOutput("skid_occ", 64'(occ1), 64'(q1.size()));
         checkOutput("pass_valid", 64'(out_valid0), 64'(q0.size() != 0));
         if (q0.size() != 0) checkOutput("pass_data", out_data0, q0[0]);
         checkOutput("pass_in_ready", 64'(in_ready0), 64'((q0.size() == 0) || ordy));
         checkOutput("pass_occ", 64'(occ0), 64'(q0.size()));
      end
      fire_in1  = v && (q1.size() < 2);
      fire_out1 = (q1.size() != 0) && ordy;
      fire_in0  = v && ((q0.size() == 0) || ordy);
      fire_out0 = (q0.size() != 0) && ordy;
      @(posedge clk);
      if (!rst_n || fl) begin
         q1.delete();
         q0.delete();
      end else begin
         if (fire_out1) popped = q1.pop_front();
         if (fire_in1) q1.push_back(d);
         if (fire_out0) popped = q0.pop_front();
         if (fire_in0) q0.push_back(d);
      end
      #1;
   endtask

   initial begin
      logic        cur_v;
      logic [63:0] cur_d;
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks_on = 1'b1;

      // Reset held with a valid input present
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b0);
         checkOutput("rst_valid", 64'(out_valid1), 64'd0);
         checkOutput("rst_data", out_data1, 64'd0);
         checkOutput("rst_ready", 64'(in_ready1), 64'd1);
         checkOutput("rst_occ", 64'(occ1), 64'd0);
      end
      applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
      checkOutput("rel_ready", 64'(in_ready1), 64'd1);
      checkOutput("rel_valid", 64'(out_valid1), 64'd0);

      // Back-to-back streaming
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b1, 64'(i), 1'b1, 1'b0);
         checkOutput("stream_valid", 64'(out_valid1), 64'd1);
         checkOutput("stream_data", out_data1, 64'(i));
         checkOutput("stream_pass_data", out_data0, 64'(i));
      end
      applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("stream_drained", 64'(out_valid1), 64'd0);

      // Backpressure fills the skid entry
      applyStimulus(1'b1, 1'b1, 64'hA, 1'b0, 1'b0);
      checkOutput("bp_hold_a", out_data1, 64'hA);
      applyStimulus(1'b1, 1'b1, 64'hB, 1'b0, 1'b0);
      checkOutput("bp_full_ready", 64'(in_ready1), 64'd0);
      checkOutput("bp_full_occ", 64'(occ1), 64'd2);
      checkOutput("bp_still_a", out_data1, 64'hA);
      applyStimulus(1'b1, 1'b1, 64'hC, 1'b0, 1'b0);
      checkOutput("bp_c_waits", 64'(occ1), 64'd2);
      applyStimulus(1'b1, 1'b1, 64'hC, 1'b1, 1'b0);
      checkOutput("bp_order_b", out_data1, 64'hB);
      applyStimulus(1'b1, 1'b1, 64'hC, 1'b1, 1'b0);
      checkOutput("bp_order_c", out_data1, 64'hC);
      applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("bp_empty", 64'(out_valid1), 64'd0);

      // Flush while full, then flush with an accepted input
      applyStimulus(1'b1, 1'b1, 64'h5, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 64'h6, 1'b0, 1'b0);
      checkOutput("fl_pre_occ", 64'(occ1), 64'd2);
      applyStimulus(1'b1, 1'b1, 64'h7, 1'b0, 1'b1);
      checkOutput("fl_valid", 64'(out_valid1), 64'd0);
      checkOutput("fl_occ", 64'(occ1), 64'd0);
      checkOutput("fl_data", out_data1, 64'd0);
      applyStimulus(1'b1, 1'b1, 64'h9, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 64'h7, 1'b1, 1'b1);
      checkOutput("fl_in_drop", 64'(out_valid1), 64'd0);
      checkOutput("fl_pass_data", out_data0, 64'd0);
      applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("fl_no_7", 64'(out_valid1), 64'd0);

      // Pass-through ready follows out_ready combinationally
      applyStimulus(1'b1, 1'b1, 64'h11, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 64'h22; out_ready = 1'b0;
      #1;
      checkOutput("pass_ready_low", 64'(in_ready0), 64'd0);
      out_ready = 1'b1;
      #1;
      checkOutput("pass_ready_high", 64'(in_ready0), 64'd1);
      applyStimulus(1'b1, 1'b1, 64'h22, 1'b1, 1'b0);
      checkOutput("pass_replace", out_data0, 64'h22);
      checkOutput("pass_replace_occ", 64'(occ0), 64'd1);

      // Reset together with flush while full
      applyStimulus(1'b1, 1'b1, 64'h31, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 64'h32, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 64'h33, 1'b1, 1'b1);
      checkOutput("mid_rst_valid", 64'(out_valid1), 64'd0);
      checkOutput("mid_rst_data", out_data1, 64'd0);
      applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("mid_rst_ready", 64'(in_ready1), 64'd1);

      // Random traffic against the FIFO models
      cur_v = 1'b0; cur_d = '0;
      for (int i = 0; i < 10000; i++) begin
         if (!(cur_v && q1.size() == 2)) begin
            cur_v = 1'($urandom_range(0, 1));
            cur_d = {32'(i), 32'($urandom())};
         end
         applyStimulus(1'b1, cur_v, cur_d, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 99) < 5));
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      checkOutput("final_valid", 64'(out_valid1), 64'd0);
      checkOutput("final_occ", 64'(occ0), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
